// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI mode-0 responder, all inputs oversampled on i_clk_sys.
// Macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting.       Rev 1.0
// ============================================================================
module spi_slave_if #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_spi_sclk,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_spi_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_tx_underrun,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  function automatic logic tx_head(input logic [DATA_W-1:0] d);
    return d[0];
  endfunction
  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] d);
    return d >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] r, input logic b);
    return {b, r[DATA_W-1:1]};
  endfunction
`else
  function automatic logic tx_head(input logic [DATA_W-1:0] d);
    return d[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] d);
    return d << 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] r, input logic b);
    return {r[DATA_W-2:0], b};
  endfunction
`endif

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
  logic              rx_pend;
  logic              do_load;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_next;

  // A CS rise in ACTIVE outranks a simultaneous SCLK edge, so no reload then.
  assign do_load   = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));
  assign load_word = o_tx_ready ? '0 : tx_buf;
  assign rx_next   = rx_insert(rx_shift, mosi_s);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_buf        <= '0;
      rx_pend       <= 1'b0;
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_tx_ready    <= 1'b1;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_rx_valid    <= rx_pend;
      rx_pend       <= 1'b0;
      o_tx_underrun <= 1'b0;

      if (do_load) begin
        tx_shift   <= tx_advance(load_word);
        o_spi_miso <= tx_head(load_word);
        if (o_tx_ready) o_tx_underrun <= 1'b1;
        else            o_tx_ready    <= 1'b1;
      end
      // Acceptance only happens while empty, so it never collides with a
      // load that drains the buffer; a load from empty leaves this word intact.
      if (i_tx_valid && o_tx_ready) begin
        tx_buf     <= i_tx_data;
        o_tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state         <= ACTIVE;
            o_spi_miso_oe <= 1'b1;
            o_busy        <= 1'b1;
            bit_cnt       <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state         <= IDLE;
            o_spi_miso_oe <= 1'b0;
            o_spi_miso    <= 1'b0;
            o_busy        <= 1'b0;
            bit_cnt       <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              o_rx_data <= rx_next;
              rx_pend   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            o_spi_miso <= tx_head(tx_shift);
            tx_shift   <= tx_advance(tx_shift);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
